// File: rtl/mda_motor_ramp_ctrl.sv
// Per-motor speed command sequencer: slews duty toward a signed target and inserts a dead-time on reversal.
// Optional watchdog that drops the target after WDOG_CYCLES without a command: define MDA_MOTOR_WDOG_EN.
module mda_motor_ramp_ctrl #(
    parameter int unsigned STEP        = 16,
    parameter int unsigned TICK_DIV    = 1000,
    parameter int unsigned DEAD_CYCLES = 5000,
    parameter int unsigned WDOG_CYCLES = 16000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] period,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_dir,
    input  logic [15:0] cmd_mag,
    output logic        on,
    output logic        dir,
    output logic [15:0] duty_cycle,
    output logic        settled
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
    localparam logic [15:0]   STEP16    = 16'(STEP);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [PW-1:0] presc;
    logic [DW-1:0] dead_cnt;
    logic [15:0]   duty;
    logic [15:0]   duty_nxt;
    logic [15:0]   tgt_mag;
    logic          tgt_dir;

    logic          accept;
    logic          tick;
    logic          reversal;
    logic          dead_done;
    logic [15:0]   clamp_mag;
    logic [15:0]   base;
    logic [15:0]   eff_tgt;
    logic [15:0]   stepped;

    function automatic logic [15:0] sat_step(input logic [15:0] gap);
        return (gap < STEP16) ? gap : STEP16;
    endfunction

    // Handshake: a command is taken on any cycle where cmd_valid && cmd_ready;
    // cmd_ready drops only while the bridge is held off between directions,
    // and the accepted target becomes visible on the following cycle.
    assign accept    = cmd_valid && cmd_ready;
    assign tick      = (presc == TICK_LAST);
    assign reversal  = (tgt_dir != dir) && (tgt_mag != 16'd0);
    assign dead_done = (dead_cnt == DEAD_LAST);
    assign clamp_mag = (cmd_mag > period) ? period : cmd_mag;

    // Ramp datapath; a lowered period pulls both the current duty and the
    // effective target down before the step is applied.
    always_comb begin
        base    = (duty > period) ? period : duty;
        eff_tgt = (tgt_mag > period) ? period : tgt_mag;
        stepped = base;
        if (reversal) begin
            stepped = base - sat_step(base);
        end else if (base < eff_tgt) begin
            stepped = base + sat_step(eff_tgt - base);
        end else if (base > eff_tgt) begin
            stepped = base - sat_step(base - eff_tgt);
        end
        duty_nxt = duty;
        if (state != ST_RUN) begin
            duty_nxt = 16'd0;
        end else if (tick) begin
            duty_nxt = stepped;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    // RUN exits look at the duty being written this cycle, so the bridge
    // turns off on the same edge the ramp reaches zero.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_OFF: begin
                if (tgt_mag != 16'd0) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (duty_nxt == 16'd0 && reversal) begin
                    state_nxt = ST_DEAD;
                end else if (duty_nxt == 16'd0 && tgt_mag == 16'd0) begin
                    state_nxt = ST_OFF;
                end
            end
            ST_DEAD: begin
                if (dead_done) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    always_comb begin
        on         = 1'b0;
        cmd_ready  = 1'b1;
        duty_cycle = 16'd0;
        settled    = 1'b0;
        case (state)
            ST_OFF: begin
                settled = (tgt_mag == 16'd0);
            end
            ST_RUN: begin
                on         = 1'b1;
                duty_cycle = duty;
                settled    = !reversal && (duty == tgt_mag);
            end
            ST_DEAD: begin
                cmd_ready = 1'b0;
            end
            default: begin
                cmd_ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc    <= '0;
            dead_cnt <= '0;
            duty     <= 16'd0;
            dir      <= 1'b0;
        end else begin
            presc    <= tick ? '0 : presc + PW'(1);
            duty     <= duty_nxt;
            dead_cnt <= (state == ST_DEAD) ? dead_cnt + DW'(1) : '0;
            if ((state == ST_OFF && tgt_mag != 16'd0) || (state == ST_DEAD && dead_done)) begin
                dir <= tgt_dir;
            end
        end
    end

`ifdef MDA_MOTOR_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES);

    logic [WW-1:0] wdog_cnt;
    logic          wdog_expired;

    assign wdog_expired = (wdog_cnt == WDOG_LAST);

    always_ff @(posedge clk) begin
        if (reset || accept) begin
            wdog_cnt <= '0;
        end else if (!wdog_expired) begin
            wdog_cnt <= wdog_cnt + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tgt_dir <= 1'b0;
            tgt_mag <= 16'd0;
        end else if (accept) begin
            tgt_dir <= cmd_dir;
            tgt_mag <= clamp_mag;
        end else if (wdog_expired) begin
            tgt_mag <= 16'd0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            tgt_dir <= 1'b0;
            tgt_mag <= 16'd0;
        end else if (accept) begin
            tgt_dir <= cmd_dir;
            tgt_mag <= clamp_mag;
        end
    end
`endif

endmodule
